alu_status_unit: RTL and testbench

//  Parametrised NZCV status register for the datapath ALU. Derives N/Z/C/V from

---
 rtl/alu_pkg.sv | 25 ++
 rtl/alu_status_unit_cond_eval.sv | 35 +++
 rtl/alu_status_unit.sv | 108 ++++++++++
 tb/tb_alu_status_unit.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU status definitions: opcodes, condition codes and the NZCV flag layout.
// Pure declarations; used by the status register and the branch unit.
// No state and no flow control.
package alu_pkg;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;

    typedef enum logic [3:0] {
        EQ, NE, CS, CC, MI, PL, VS, VC,
        HI, LS, GE, LT, GT, LE, AL, NV
    } cond_e;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } flags_t;

    function automatic logic is_arith(input logic [3:0] op);
        return (op == ALU_ADD) || (op == ALU_SUB);
    endfunction

endpackage

// File: rtl/alu_status_unit_cond_eval.sv
// Evaluates an ARM-style condition code against an NZCV flag set.
// Latency: combinational, zero cycles.
// Backpressure: none; output is valid whenever the inputs are.
module cond_eval
    import alu_pkg::*;
(
    input  flags_t     flags,
    input  cond_e      cond,
    output logic       cond_true
);

    always_comb begin
        cond_true = 1'b0;
        case (cond)
            EQ:      cond_true = flags.z;
            NE:      cond_true = ~flags.z;
            CS:      cond_true = flags.c;
            CC:      cond_true = ~flags.c;
            MI:      cond_true = flags.n;
            PL:      cond_true = ~flags.n;
            VS:      cond_true = flags.v;
            VC:      cond_true = ~flags.v;
            HI:      cond_true = flags.c & ~flags.z;
            LS:      cond_true = ~flags.c | flags.z;
            GE:      cond_true = (flags.n == flags.v);
            LT:      cond_true = (flags.n != flags.v);
            GT:      cond_true = ~flags.z & (flags.n == flags.v);
            LE:      cond_true = flags.z | (flags.n != flags.v);
            AL:      cond_true = 1'b1;
            NV:      cond_true = 1'b0;
            default: cond_true = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_status_unit.sv
// NZCV status register with sticky overflow, saturating overflow counter and condition check.
// Latency: 1 clk from valid&set_flags or flags_wr to flags; cond_true is combinational.
// Backpressure: none; every strobe is accepted on the edge it is presented.
module alu_status_unit
    import alu_pkg::*;
#(
    parameter int N       = 4,
    parameter int CNT_W   = 8,
    parameter bit FORWARD = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid,
    input  logic             set_flags,
    input  logic [3:0]       alu_control,
    input  logic [N-1:0]     a,
    input  logic [N-1:0]     b,
    input  logic [N-1:0]     result,
    input  logic             flags_wr,
    input  logic [3:0]       flags_wdata,
    input  logic             clr_sticky,
    input  logic             clr_count,
    input  logic [3:0]       cond,
    output logic [3:0]       flags,
    output logic             sticky_v,
    output logic [CNT_W-1:0] ovf_count,
    output logic             cond_true
);

    flags_t           flags_q, flags_d, flags_calc, cond_src;
    logic             sticky_q, sticky_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             upd, commit_ovf;
    logic [N-1:0]     a_g, b_g, res_g;
    logic [N:0]       sum;

    // Operands are masked when not valid so nothing undefined reaches the flags.
    always_comb begin
        a_g   = valid ? a      : '0;
        b_g   = valid ? b      : '0;
        res_g = valid ? result : '0;
        upd   = valid & set_flags;
        sum   = {1'b0, a_g} + {1'b0, b_g};

        flags_calc   = flags_q;
        flags_calc.n = res_g[N-1];
        flags_calc.z = ~|res_g;
        if (alu_control == ALU_ADD) begin
            flags_calc.c = sum[N];
            flags_calc.v = (a_g[N-1] == b_g[N-1]) & (res_g[N-1] != a_g[N-1]);
        end else if (alu_control == ALU_SUB) begin
            flags_calc.c = (a_g >= b_g);
            flags_calc.v = (a_g[N-1] != b_g[N-1]) & (res_g[N-1] != a_g[N-1]);
        end
    end

    always_comb begin
        if (flags_wr) begin
            flags_d = flags_t'(flags_wdata);
        end else if (upd) begin
            flags_d = flags_calc;
        end else begin
            flags_d = flags_q;
        end

        commit_ovf = upd & ~flags_wr & is_arith(alu_control) & flags_calc.v;

        // A committed overflow wins over a same-edge clear; a clear restarts the count.
        sticky_d = sticky_q;
        cnt_d    = cnt_q;
        if (commit_ovf) begin
            sticky_d = 1'b1;
            if (clr_count) begin
                cnt_d = CNT_W'(1);
            end else if (!(&cnt_q)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            if (clr_sticky) sticky_d = 1'b0;
            if (clr_count)  cnt_d    = '0;
        end

        cond_src = (FORWARD && (flags_wr || upd)) ? flags_d : flags_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q  <= '0;
            sticky_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            flags_q  <= flags_d;
            sticky_q <= sticky_d;
            cnt_q    <= cnt_d;
        end
    end

    cond_eval u_cond_eval (
        .flags     (cond_src),
        .cond      (cond_e'(cond)),
        .cond_true (cond_true)
    );

    assign flags     = flags_q;
    assign sticky_v  = sticky_q;
    assign ovf_count = cnt_q;

endmodule

// File: tb/tb_alu_status_unit.sv
// Randomised and directed bench for alu_status_unit with a behavioural NZCV model.
module tb_alu_status_unit;

    localparam int N     = 4;
    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             valid, set_flags, flags_wr, clr_sticky, clr_count;
    logic [3:0]       alu_control, flags_wdata, cond;
    logic [N-1:0]     a, b, result;
    logic [3:0]       flags, flags_nf;
    logic             sticky_v, sticky_nf, cond_true, cond_true_nf;
    logic [CNT_W-1:0] ovf_count, count_nf;

    int n_tests = 0;
    int n_fail  = 0;

    logic [3:0] m_flags;
    logic       m_sticky;
    int         m_count;

    always #5 clk = ~clk;

    alu_status_unit #(.N(N), .CNT_W(CNT_W), .FORWARD(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .valid(valid), .set_flags(set_flags),
        .alu_control(alu_control), .a(a), .b(b), .result(result),
        .flags_wr(flags_wr), .flags_wdata(flags_wdata), .clr_sticky(clr_sticky),
        .clr_count(clr_count), .cond(cond), .flags(flags), .sticky_v(sticky_v),
        .ovf_count(ovf_count), .cond_true(cond_true)
    );

    alu_status_unit #(.N(N), .CNT_W(CNT_W), .FORWARD(1'b0)) dut_nf (
        .clk(clk), .rst_n(rst_n), .valid(valid), .set_flags(set_flags),
        .alu_control(alu_control), .a(a), .b(b), .result(result),
        .flags_wr(flags_wr), .flags_wdata(flags_wdata), .clr_sticky(clr_sticky),
        .clr_count(clr_count), .cond(cond), .flags(flags_nf), .sticky_v(sticky_nf),
        .ovf_count(count_nf), .cond_true(cond_true_nf)
    );

    // Flags the current inputs would produce, from signed/unsigned integer arithmetic.
    function automatic logic [3:0] model_next(output logic ovf);
        int ua, ub, sa, sb, s;
        logic [3:0] f;
        ua  = a;
        ub  = b;
        sa  = (ua >= 8) ? ua - 16 : ua;
        sb  = (ub >= 8) ? ub - 16 : ub;
        f   = m_flags;
        ovf = 1'b0;
        if (flags_wr) return flags_wdata;
        if (!(valid && set_flags)) return m_flags;
        f[3] = result[N-1];
        f[2] = (result == 0);
        if (alu_control == 4'd0) begin
            s    = sa + sb;
            f[1] = (ua + ub) > 15;
            f[0] = (s > 7) || (s < -8);
            ovf  = f[0];
        end else if (alu_control == 4'd1) begin
            s    = sa - sb;
            f[1] = (ua >= ub);
            f[0] = (s > 7) || (s < -8);
            ovf  = f[0];
        end
        return f;
    endfunction

    function automatic logic cond_ref(input logic [3:0] cc, input logic [3:0] f);
        logic fn, fz, fc, fv;
        {fn, fz, fc, fv} = f;
        case (cc)
            4'h0: return fz;
            4'h1: return !fz;
            4'h2: return fc;
            4'h3: return !fc;
            4'h4: return fn;
            4'h5: return !fn;
            4'h6: return fv;
            4'h7: return !fv;
            4'h8: return fc && !fz;
            4'h9: return !fc || fz;
            4'hA: return fn == fv;
            4'hB: return fn != fv;
            4'hC: return !fz && (fn == fv);
            4'hD: return fz || (fn != fv);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_commit();
        logic [3:0] nf;
        logic       ovf;
        if (!rst_n) begin
            m_flags = 4'b0; m_sticky = 1'b0; m_count = 0;
        end else begin
            nf = model_next(ovf);
            if (ovf) begin
                m_sticky = 1'b1;
                if (clr_count) m_count = 1;
                else if (m_count < 3) m_count = m_count + 1;
            end else begin
                if (clr_sticky) m_sticky = 1'b0;
                if (clr_count)  m_count  = 0;
            end
            m_flags = nf;
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic idle();
        valid = 0; set_flags = 0; flags_wr = 0; flags_wdata = 0;
        clr_sticky = 0; clr_count = 0; alu_control = 0;
        a = 0; b = 0; result = 0;
    endtask

    task automatic drive_op(input logic [3:0] op, input logic [3:0] ia,
                            input logic [3:0] ib, input logic [3:0] ir);
        valid = 1; set_flags = 1; alu_control = op; a = ia; b = ib; result = ir;
    endtask

    task automatic test_reset();
        idle(); cond = 4'h0; rst_n = 0;
        #2;
        n_tests++;
        if (flags !== 4'b0000 || sticky_v !== 1'b0 || ovf_count !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_initial: got flags=%b sticky=%b cnt=%0d want 0000/0/0", flags, sticky_v, ovf_count);
        end
        m_flags = 0; m_sticky = 0; m_count = 0;
        @(negedge clk); rst_n = 1;
    endtask

    task automatic test_add_ovf();
        @(negedge clk);
        drive_op(4'd0, 4'd7, 4'd1, 4'd8); cond = 4'h6;
        #1;
        n_tests++;
        if (cond_true !== 1'b1) begin
            n_fail++; $display("FAIL add_vs_forward: got %b want 1", cond_true);
        end
        n_tests++;
        if (cond_true_nf !== 1'b0) begin
            n_fail++; $display("FAIL add_vs_registered: got %b want 0", cond_true_nf);
        end
        cyc();
        n_tests++;
        if (flags !== 4'b1001 || sticky_v !== 1'b1 || ovf_count !== 2'd1) begin
            n_fail++;
            $display("FAIL add_ovf: got flags=%b sticky=%b cnt=%0d want 1001/1/1", flags, sticky_v, ovf_count);
        end
    endtask

    task automatic test_sub();
        @(negedge clk);
        drive_op(4'd1, 4'd3, 4'd3, 4'd0);
        cyc();
        n_tests++;
        if (flags !== 4'b0110) begin
            n_fail++; $display("FAIL sub_equal: got %b want 0110", flags);
        end
        @(negedge clk);
        drive_op(4'd1, 4'd2, 4'd5, 4'hD); cond = 4'hB;
        #1;
        n_tests++;
        if (cond_true !== 1'b1) begin
            n_fail++; $display("FAIL sub_lt_forward: got %b want 1", cond_true);
        end
        cyc();
        n_tests++;
        if (flags !== 4'b1000) begin
            n_fail++; $display("FAIL sub_borrow: got %b want 1000", flags);
        end
        @(negedge clk); idle(); #1;
        n_tests++;
        if (cond_true !== 1'b1 || cond_true_nf !== 1'b1) begin
            n_fail++; $display("FAIL sub_lt_reg: got %b/%b want 1/1", cond_true, cond_true_nf);
        end
    endtask

    task automatic test_logic_preserve();
        @(negedge clk);
        idle(); flags_wr = 1; flags_wdata = 4'b0011;
        cyc();
        @(negedge clk);
        idle(); drive_op(4'd2, 4'd5, 4'd10, 4'd0);
        cyc();
        n_tests++;
        if (flags !== 4'b0111) begin
            n_fail++; $display("FAIL logic_keep_cv: got %b want 0111", flags);
        end
        @(negedge clk); idle(); cond = 4'hB; #1;
        n_tests++;
        if (cond_true !== 1'b1) begin
            n_fail++; $display("FAIL logic_lt: got %b want 1", cond_true);
        end
        cond = 4'hA; #1;
        n_tests++;
        if (cond_true !== 1'b0) begin
            n_fail++; $display("FAIL logic_ge: got %b want 0", cond_true);
        end
    endtask

    task automatic test_saturation();
        @(negedge clk);
        idle(); clr_sticky = 1; clr_count = 1;
        cyc();
        n_tests++;
        if (sticky_v !== 1'b0 || ovf_count !== 2'd0) begin
            n_fail++; $display("FAIL clear: got sticky=%b cnt=%0d want 0/0", sticky_v, ovf_count);
        end
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            idle(); drive_op(4'd0, 4'd7, 4'd1, 4'd8);
            cyc();
            n_tests++;
            if (ovf_count !== ((i > 3) ? 2'd3 : 2'(i))) begin
                n_fail++; $display("FAIL saturate_%0d: got %0d want %0d", i, ovf_count, (i > 3) ? 3 : i);
            end
        end
        @(negedge clk);
        drive_op(4'd0, 4'd7, 4'd1, 4'd8); clr_sticky = 1; clr_count = 1;
        cyc();
        n_tests++;
        if (sticky_v !== 1'b1 || ovf_count !== 2'd1) begin
            n_fail++; $display("FAIL set_beats_clear: got sticky=%b cnt=%0d want 1/1", sticky_v, ovf_count);
        end
    endtask

    task automatic test_flags_wr();
        @(negedge clk);
        idle(); drive_op(4'd0, 4'd7, 4'd1, 4'd8);
        flags_wr = 1; flags_wdata = 4'b1010; cond = 4'h6;
        #1;
        n_tests++;
        if (cond_true !== 1'b0 || cond_true_nf !== 1'b1) begin
            n_fail++; $display("FAIL wr_vs_forward: got %b/%b want 0/1", cond_true, cond_true_nf);
        end
        cyc();
        n_tests++;
        if (flags !== 4'b1010 || ovf_count !== 2'd1 || sticky_v !== 1'b1) begin
            n_fail++;
            $display("FAIL wr_priority: got flags=%b cnt=%0d sticky=%b want 1010/1/1", flags, ovf_count, sticky_v);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        idle(); drive_op(4'd0, 4'd7, 4'd1, 4'd8);
        #2 rst_n = 0;
        #1;
        n_tests++;
        if (flags !== 4'b0 || sticky_v !== 1'b0 || ovf_count !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_async: got flags=%b sticky=%b cnt=%0d want 0000/0/0", flags, sticky_v, ovf_count);
        end
        cyc();
        n_tests++;
        if (flags !== 4'b0 || ovf_count !== 2'd0) begin
            n_fail++; $display("FAIL reset_discard: got flags=%b cnt=%0d want 0000/0", flags, ovf_count);
        end
        @(negedge clk); idle(); rst_n = 1;
        cyc();
        n_tests++;
        if (flags !== 4'b0 || sticky_v !== 1'b0 || ovf_count !== 2'd0) begin
            n_fail++; $display("FAIL reset_release: got flags=%b sticky=%b cnt=%0d", flags, sticky_v, ovf_count);
        end
    endtask

    task automatic test_random();
        logic [3:0] nf;
        logic       ovf, exp_fwd;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            valid       = ($urandom_range(0, 3) != 0);
            set_flags   = ($urandom_range(0, 2) != 0);
            case ($urandom_range(0, 3))
                0:       alu_control = 4'd0;
                1:       alu_control = 4'd1;
                default: alu_control = 4'($urandom_range(2, 15));
            endcase
            a           = 4'($urandom);
            b           = 4'($urandom);
            if (alu_control == 4'd0)      result = a + b;
            else if (alu_control == 4'd1) result = a - b;
            else                          result = 4'($urandom);
            flags_wr    = ($urandom_range(0, 9) == 0);
            flags_wdata = 4'($urandom);
            clr_sticky  = ($urandom_range(0, 11) == 0);
            clr_count   = ($urandom_range(0, 11) == 0);
            cond        = 4'($urandom);
            #1;
            nf      = model_next(ovf);
            exp_fwd = cond_ref(cond, (flags_wr || (valid && set_flags)) ? nf : m_flags);
            n_tests++;
            if (cond_true !== exp_fwd) begin
                n_fail++; $display("FAIL rnd_cond_fwd[%0d]: got %b want %b", i, cond_true, exp_fwd);
            end
            n_tests++;
            if (cond_true_nf !== cond_ref(cond, m_flags)) begin
                n_fail++; $display("FAIL rnd_cond_reg[%0d]: got %b want %b", i, cond_true_nf, cond_ref(cond, m_flags));
            end
            cyc();
            n_tests++;
            if (flags !== m_flags || sticky_v !== m_sticky || ovf_count !== m_count[1:0]) begin
                n_fail++;
                $display("FAIL rnd_state[%0d]: got %b/%b/%0d want %b/%b/%0d", i,
                         flags, sticky_v, ovf_count, m_flags, m_sticky, m_count);
            end
            n_tests++;
            if (flags_nf !== m_flags || sticky_nf !== m_sticky || count_nf !== m_count[1:0]) begin
                n_fail++;
                $display("FAIL rnd_state_nf[%0d]: got %b/%b/%0d want %b/%b/%0d", i,
                         flags_nf, sticky_nf, count_nf, m_flags, m_sticky, m_count);
            end
        end
    endtask

    initial begin
        test_reset();
        test_add_ovf();
        test_sub();
        test_logic_preserve();
        test_saturation();
        test_flags_wr();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
